// File: rtl/fifo_pkg.sv
// Shared FIFO definitions used by both the write- and read-side controllers.
// Latency: n/a (constants and pure combinational helper functions only).
// Backpressure: n/a.
package fifo_pkg;

    // Default RAM address width; depth is 2**FIFO_ADDR entries.
    localparam int FIFO_ADDR = 5;

    // Pointer helpers work on a 32-bit container; callers zero-extend the
    // pointer in and truncate the result back to their own pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Gray-to-binary converter for an async FIFO pointer of W bits.
// Latency: purely combinational, zero cycles.
// Backpressure: none; ports are gray (in) and bin (out).
module fifo_gray2bin
    import fifo_pkg::*;
#(
    parameter int W = FIFO_ADDR + 1
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    assign bin = W'(gray2bin(32'(gray)));

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write-side controller: write address/strobe, gray write pointer, full/afull/occupancy/overflow flags.
// Latency: wclken/waddr combinational; wptr, full, afull, wcount, ovf update on the edge that accepts a write.
// Backpressure: writes are dropped while full (wclken held low) and the sticky ovf flag records the attempt.
// Ports: clk, reset_b (async active-low), wr_en, rptr_wr (synced gray read ptr), clr_ovf ->
//        waddr, wclken, wptr (gray), full, afull, wcount, ovf.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR     = FIFO_ADDR,
    parameter int AFULL_TH = 28
) (
    input  logic            clk,
    input  logic            reset_b,
    input  logic            wr_en,
    input  logic [ADDR:0]   rptr_wr,
    input  logic            clr_ovf,
    output logic [ADDR-1:0] waddr,
    output logic            wclken,
    output logic [ADDR:0]   wptr,
    output logic            full,
    output logic            afull,
    output logic [ADDR:0]   wcount,
    output logic            ovf
);

    localparam int PW = ADDR + 1;
    localparam logic [ADDR:0] AFULL_V = PW'(AFULL_TH);

    logic [ADDR:0] wbin;
    logic [ADDR:0] wbin_next;
    logic [ADDR:0] wgray_next;
    logic [ADDR:0] rbin;
    logic [ADDR:0] wcount_next;
    logic [ADDR:0] full_gray;

    assign wclken = wr_en & ~full;
    assign waddr  = wbin[ADDR-1:0];

    assign wbin_next  = wbin + {{ADDR{1'b0}}, wclken};
    assign wgray_next = PW'(bin2gray(32'(wbin_next)));

    // Full when the write pointer is exactly one lap ahead of the read
    // pointer: in gray code that means the two MSBs differ and the rest match.
    assign full_gray = {~rptr_wr[ADDR:ADDR-1], rptr_wr[ADDR-2:0]};

    fifo_gray2bin #(
        .W (PW)
    ) u_rptr_g2b (
        .gray (rptr_wr),
        .bin  (rbin)
    );

    // Modulo subtraction handles pointer wrap. Because rptr_wr lags the
    // reader, this occupancy can only over-estimate, so full never drops early.
    assign wcount_next = wbin_next - rbin;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wbin   <= '0;
            wptr   <= '0;
            full   <= 1'b0;
            afull  <= 1'b0;
            wcount <= '0;
            ovf    <= 1'b0;
        end else begin
            wbin   <= wbin_next;
            wptr   <= wgray_next;
            full   <= (wgray_next == full_gray);
            afull  <= (wcount_next >= AFULL_V);
            wcount <= wcount_next;
            // A fresh overflow takes priority over a simultaneous clear.
            ovf    <= (wr_en & full) | (ovf & ~clr_ovf);
        end
    end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl (ADDR=5, AFULL_TH=28).
// Reference model tracks total writes accepted and reader position as integers.
// Directed fill/overflow/release/simultaneous/reset/wrap phases, then a random phase.
module tb_fifo_wr_ctrl;

    localparam int ADDR  = 5;
    localparam int DEPTH = 32;
    localparam int TH    = 28;

    logic         clk;
    logic         reset_b;
    logic         wr_en;
    logic [5:0]   rptr_wr;
    logic         clr_ovf;
    logic [4:0]   waddr;
    logic         wclken;
    logic [5:0]   wptr;
    logic         full;
    logic         afull;
    logic [5:0]   wcount;
    logic         ovf;

    fifo_wr_ctrl #(
        .ADDR     (ADDR),
        .AFULL_TH (TH)
    ) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .wr_en   (wr_en),
        .rptr_wr (rptr_wr),
        .clr_ovf (clr_ovf),
        .waddr   (waddr),
        .wclken  (wclken),
        .wptr    (wptr),
        .full    (full),
        .afull   (afull),
        .wcount  (wcount),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: plain counts, not pointers.
    int m_wr;       // total writes accepted since reset
    int m_rd;       // reader position currently presented on rptr_wr
    bit m_full;
    bit m_ovf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] to_gray(input int v);
        logic [5:0] b;
        b = 6'(v % 64);
        return b ^ (b >> 1);
    endfunction

    function automatic int popcnt(input logic [5:0] v);
        int c = 0;
        for (int i = 0; i < 6; i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_full = 0; m_ovf = 0;
    endtask

    // One clock of stimulus. Called shortly after a rising edge.
    task automatic step(input bit wr, input bit clr, input int rd, output bit acc);
        int occ;
        wr_en   = wr;
        clr_ovf = clr;
        rptr_wr = to_gray(rd);
        #1;
        acc = wr && !m_full;
        chk("wclken", 32'(wclken), 32'(acc));
        chk("waddr", 32'(waddr), 32'(m_wr % DEPTH));
        @(posedge clk);
        m_ovf = (wr && m_full) || (m_ovf && !clr);
        if (acc) m_wr++;
        m_rd = rd;
        occ = (m_wr - m_rd) % 64;
        m_full = (occ == DEPTH);
        #1;
        chk("wptr", 32'(wptr), 32'(to_gray(m_wr)));
        chk("full", 32'(full), 32'(m_full));
        chk("afull", 32'(afull), 32'(occ >= TH));
        chk("wcount", 32'(wcount), 32'(occ));
        chk("ovf", 32'(ovf), 32'(m_ovf));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wptr"}, 32'(wptr), 0);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_afull"}, 32'(afull), 0);
        chk({tag, "_wcount"}, 32'(wcount), 0);
        chk({tag, "_ovf"}, 32'(ovf), 0);
        chk({tag, "_waddr"}, 32'(waddr), 0);
    endtask

    initial begin
        bit acc;
        int wraps;
        int hist[$];
        logic [5:0] prev;

        reset_b = 1'b0; wr_en = 1'b0; clr_ovf = 1'b0; rptr_wr = '0;
        model_reset();
        #3;
        chk_all_zero("reset");
        @(posedge clk); @(posedge clk);
        #2 reset_b = 1'b1;
        @(posedge clk); #1;

        // Fill from empty with the reader parked at 0.
        for (int i = 1; i <= 32; i++) begin
            step(1, 0, 0, acc);
            chk("fill_acc", 32'(acc), 1);
            if (i == 27) chk("afull_27", 32'(afull), 0);
            if (i == 28) chk("afull_28", 32'(afull), 1);
            if (i == 31) chk("full_31", 32'(full), 0);
        end
        chk("fill_full", 32'(full), 1);
        chk("fill_wcount", 32'(wcount), 32);
        chk("fill_wptr", 32'(wptr), 32'(6'b110000));

        // Overflow, clear, and clear colliding with a fresh overflow.
        prev = wptr;
        step(1, 0, 0, acc);
        chk("ovf_set", 32'(ovf), 1);
        chk("ovf_wptr_hold", 32'(wptr), 32'(prev));
        step(0, 1, 0, acc);
        chk("ovf_clr", 32'(ovf), 0);
        step(1, 1, 0, acc);
        chk("ovf_set_wins", 32'(ovf), 1);

        // Reader moves to 4 then 5.
        step(0, 1, 4, acc);
        chk("rel_full", 32'(full), 0);
        chk("rel_wcount", 32'(wcount), 28);
        chk("rel_afull", 32'(afull), 1);
        step(0, 0, 5, acc);
        chk("rel2_wcount", 32'(wcount), 27);
        chk("rel2_afull", 32'(afull), 0);

        // Bring occupancy to 31, then write and read together.
        for (int i = 0; i < 4; i++) step(1, 0, 5, acc);
        chk("sim_pre", 32'(wcount), 31);
        step(1, 0, 6, acc);
        chk("sim_full", 32'(full), 0);
        chk("sim_wcount", 32'(wcount), 31);

        // Reset mid-burst: outputs clear without a clock edge.
        wr_en = 1'b1; clr_ovf = 1'b0;
        #2 reset_b = 1'b0;
        #1 chk_all_zero("midrst");
        wr_en = 1'b0;
        @(posedge clk);
        @(negedge clk) reset_b = 1'b1;
        model_reset();
        @(posedge clk); #1;
        step(1, 0, 0, acc);
        chk("post_rst_acc", 32'(acc), 1);

        // Wrap run: reader trails the writer by four cycles.
        hist.delete();
        wraps = 0;
        for (int i = 0; i < 200; i++) begin
            int rd;
            hist.push_back(m_wr);
            rd = (hist.size() > 4) ? hist[hist.size() - 5] : 0;
            prev = wptr;
            step(1, 0, rd, acc);
            chk("wrap_ham", 32'(popcnt(prev ^ wptr)), 32'(acc ? 1 : 0));
            chk("wrap_nofull", 32'(full), 0);
            if (acc && wptr == 6'd0) wraps++;
        end
        chk("wrap_count", 32'(wraps), 3);

        // Random traffic; reader never passes writes older than 3 cycles.
        hist.delete();
        for (int i = 0; i < 1500; i++) begin
            int lim;
            int rd;
            bit wr;
            bit clr;
            hist.push_back(m_wr);
            lim = (hist.size() > 3) ? hist[hist.size() - 4] : m_rd;
            rd = m_rd;
            if (rd < lim && $urandom_range(0, 99) < 40) rd++;
            wr  = ($urandom_range(0, 99) < 65);
            clr = ($urandom_range(0, 99) < 10);
            step(wr, clr, rd, acc);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

endmodule
